// File: rtl/lcd_hd44780_ctrl_if.sv
// Host-side handshake for the HD44780 controller: display configuration,
// request strobe, command/data word and the busy indication.
interface lcd_hd44780_ctrl_if;
    logic [6:0] in_data;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       busy;

    modport master (
        output in_data,
        output lcd_enable,
        output lcd_bus,
        input  busy
    );

    modport slave (
        input  in_data,
        input  lcd_enable,
        input  lcd_bus,
        output busy
    );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780-class character LCD controller: power-up wait, mode preamble, init
// sequence, then host byte transfers over an 8-bit or 4-bit (nibble) bus.
module lcd_hd44780_ctrl #(
    parameter int CLK_MHZ    = 45,
    parameter int BUS4       = 0,
    parameter int POWERUP_US = 500,
    parameter int SETUP_US   = 1,
    parameter int PULSE_US   = 13,
    parameter int CMD_US     = 50,
    parameter int LONG_US    = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_hd44780_ctrl_if.slave     host,
    output logic                  e,
    output logic [7:0]            lcd_data,
    output logic                  rw,
    output logic                  rs
);

    localparam int  PRE0_US = 4100;
    localparam int  PRE1_US = 100;
    localparam int  MAX_A   = (POWERUP_US > PRE0_US) ? POWERUP_US : PRE0_US;
    localparam int  MAX_US  = (MAX_A > LONG_US) ? MAX_A : LONG_US;
    localparam int  CW      = $clog2(MAX_US * CLK_MHZ + 1);
    localparam bit  NIB     = (BUS4 != 0);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t POWERUP_C = cnt_t'(POWERUP_US * CLK_MHZ);
    localparam cnt_t SETUP_C   = cnt_t'(SETUP_US * CLK_MHZ);
    localparam cnt_t PEND_C    = cnt_t'((SETUP_US + PULSE_US) * CLK_MHZ);
    localparam cnt_t HIGH_C    = cnt_t'((SETUP_US + 2 * PULSE_US) * CLK_MHZ);
    localparam cnt_t CMD_C     = cnt_t'(CMD_US * CLK_MHZ);
    localparam cnt_t LONG_C    = cnt_t'(LONG_US * CLK_MHZ);
    localparam cnt_t PRE0_C    = cnt_t'(PRE0_US * CLK_MHZ);
    localparam cnt_t PRE1_C    = cnt_t'(PRE1_US * CLK_MHZ);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_PREAMBLE,
        ST_INIT,
        ST_READY,
        ST_SEND
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [1:0] step_q, step_d;
    logic       nib_q, nib_d;
    logic [7:0] byte_q, byte_d;
    logic       rsb_q, rsb_d;
    logic       rwb_q, rwb_d;
    logic [6:0] cfg_q, cfg_d;

    logic       e_q, e_d;
    logic [7:0] data_q, data_d;
    logic       rs_q, rs_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    logic       phaseEnd;

    // Length of the current transfer phase; in nibble mode the high nibble
    // always gets the short fixed window, the low nibble the full one.
    function automatic cnt_t phaseWindow(state_t st, logic [1:0] stp, logic nb,
                                         logic [7:0] b, logic rsb);
        cnt_t w;
        logic longCmd;
        longCmd = !rsb && (b == 8'h01 || b == 8'h02 || b == 8'h03);
        w = longCmd ? LONG_C : CMD_C;
        if (st == ST_PREAMBLE) begin
            if (!NIB || stp == 2'd0) begin
                w = PRE0_C;
            end else if (stp == 2'd1) begin
                w = PRE1_C;
            end else begin
                w = CMD_C;
            end
        end else if (NIB && !nb) begin
            w = HIGH_C;
        end
        return w;
    endfunction

    function automatic logic [7:0] initByte(logic [1:0] stp, logic [6:0] cfg);
        logic [7:0] b;
        case (stp)
            2'd0:    b = {3'b001, ~NIB, cfg[6], cfg[5], 2'b00};
            2'd1:    b = {5'b00001, cfg[4:2]};
            2'd2:    b = 8'h01;
            default: b = {6'b000001, cfg[1:0]};
        endcase
        return b;
    endfunction

    function automatic logic [7:0] beatData(state_t st, logic [1:0] stp, logic nb,
                                            logic [7:0] b);
        logic [7:0] d;
        d = 8'h00;
        case (st)
            ST_PREAMBLE: d = (NIB && stp == 2'd3) ? 8'h20 : 8'h30;
            ST_INIT, ST_SEND: begin
                if (!NIB) begin
                    d = b;
                end else begin
                    d = nb ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
                end
            end
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    assign phaseEnd = (cnt_q == phaseWindow(state_q, step_q, nib_q, byte_q, rsb_q) - cnt_t'(1));

    // Sequencing of power-up, preamble, init and host transfers.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '1) ? cnt_q + cnt_t'(1) : cnt_q;
        step_d  = step_q;
        nib_d   = nib_q;
        byte_d  = byte_q;
        rsb_d   = rsb_q;
        rwb_d   = rwb_q;
        cfg_d   = cfg_q;
        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == POWERUP_C - cnt_t'(1)) begin
                    cfg_d   = host.in_data;
                    state_d = ST_PREAMBLE;
                    step_d  = 2'd0;
                    cnt_d   = '0;
                end
            end
            ST_PREAMBLE: begin
                if (phaseEnd) begin
                    cnt_d = '0;
                    if (!NIB || step_q == 2'd3) begin
                        state_d = ST_INIT;
                        step_d  = 2'd0;
                        byte_d  = initByte(2'd0, cfg_q);
                        rsb_d   = 1'b0;
                        rwb_d   = 1'b0;
                        nib_d   = 1'b0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            ST_INIT: begin
                if (phaseEnd) begin
                    cnt_d = '0;
                    if (NIB && !nib_q) begin
                        nib_d = 1'b1;
                    end else if (step_q == 2'd3) begin
                        state_d = ST_READY;
                    end else begin
                        step_d = step_q + 2'd1;
                        byte_d = initByte(step_q + 2'd1, cfg_q);
                        nib_d  = 1'b0;
                    end
                end
            end
            ST_READY: begin
                cnt_d = '0;
                if (host.lcd_enable) begin
                    state_d = ST_SEND;
                    byte_d  = host.lcd_bus[7:0];
                    rsb_d   = host.lcd_bus[9];
                    rwb_d   = host.lcd_bus[8];
                    nib_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (phaseEnd) begin
                    cnt_d = '0;
                    if (NIB && !nib_q) begin
                        nib_d = 1'b1;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state so they leave a flop.
    always_comb begin
        e_d    = 1'b0;
        data_d = 8'h00;
        rs_d   = 1'b0;
        rw_d   = 1'b0;
        busy_d = 1'b1;
        case (state_d)
            ST_PREAMBLE, ST_INIT, ST_SEND: begin
                e_d    = (cnt_d >= SETUP_C) && (cnt_d < PEND_C);
                data_d = beatData(state_d, step_d, nib_d, byte_d);
                rs_d   = (state_d != ST_PREAMBLE) && rsb_d;
                rw_d   = (state_d != ST_PREAMBLE) && rwb_d;
            end
            ST_READY: busy_d = 1'b0;
            default: busy_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_POWERUP;
            cnt_q   <= '0;
            step_q  <= 2'd0;
            nib_q   <= 1'b0;
            byte_q  <= 8'h00;
            rsb_q   <= 1'b0;
            rwb_q   <= 1'b0;
            cfg_q   <= 7'h00;
            e_q     <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            nib_q   <= nib_d;
            byte_q  <= byte_d;
            rsb_q   <= rsb_d;
            rwb_q   <= rwb_d;
            cfg_q   <= cfg_d;
            e_q     <= e_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
        end
    end

    assign e         = e_q;
    assign lcd_data  = data_q;
    assign rs        = rs_q;
    assign rw        = rw_q;
    assign host.busy = busy_q;

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Parametrised HD44780-class character-LCD controller.
- Performs the power-up wait, the mode preamble and the 4-command init sequence, then accepts host command/data bytes over a busy/enable handshake.
- Supports 8-bit and 4-bit (nibble) bus modes and a clock-frequency parameter.
- Adds a long wait for clear/home commands.
- Sits between the display-host logic and the LCD pins.

Parameters:
- CLK_MHZ, 45, clock cycles per microsecond; every timing below is in µs × CLK_MHZ cycles.
- BUS4, 0, 1 = 4-bit bus on lcd_data[7:4]; 0 = 8-bit bus.
- POWERUP_US, 500, power-up wait.
- SETUP_US, 1, e-low setup before each e pulse.
- PULSE_US, 13, e-high width.
- CMD_US, 50, normal per-byte transfer window.
- LONG_US, 2000, transfer window for clear (0x01) and home (0x02/0x03) with rs=0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  7  {N lines, F font, D display, C cursor, B blink, I/D, S}; sampled once at end of power-up.
- lcd_enable  input  1  host request; honoured only in READY.
- lcd_bus  input  10  {rs, rw, data[7:0]}; captured on acceptance.
- e  output  1  LCD enable strobe.
- lcd_data  output  8  LCD data bus; in BUS4 mode the nibble is on [7:4] and [3:0]=0.
- rw  output  1  LCD read/write.
- rs  output  1  LCD register select.
- busy  output  1  controller not ready for a request.

Behaviour:
- All outputs are registered (updated on the clock edge). One clock, synchronous active-high reset.
- Reset: e=0, lcd_data=0, rw=0, rs=0, busy=1, state=POWERUP, counters=0.
  - Reset asserted at any point aborts the current transfer immediately; the next cycle shows the reset values.
- States:
  - POWERUP: busy=1 and e=0 for POWERUP_US×CLK_MHZ cycles, counted from the first cycle after rst deasserts. In the last cycle in_data is latched, then the state moves to PREAMBLE.
  - PREAMBLE, BUS4=0: one byte 0x30 with a 4100 µs window.
  - PREAMBLE, BUS4=1: single nibbles 0x3 (4100 µs window), 0x3 (100 µs), 0x3 (CMD_US), 0x2 (CMD_US).
  - INIT: four bytes through the byte engine with rs=0, rw=0:
    - Function set: {3'b001, ~BUS4, N, F, 2'b00}.
    - Display control: {5'b00001, D, C, B}.
    - Clear: 0x01, using the LONG window.
    - Entry mode: {6'b000001, I/D, S}.
  - READY: busy=0, e=0, rs=0, rw=0, lcd_data=0.
    - If lcd_enable=1, lcd_bus is captured and the state moves to SEND.
    - busy=1, rs/rw and the first data beat appear on the next cycle.
  - SEND: the byte engine runs on the captured byte; at the end of its window the state returns to READY. At least one READY cycle with busy=0 occurs before the next acceptance.
- Nibble/byte pulse: SETUP cycles with e=0, then PULSE cycles with e=1, then e=0. rs, rw and lcd_data are stable for the whole pulse and its window.
- Byte engine, 8-bit mode: one pulse. Total window is CMD_US×CLK_MHZ cycles, or LONG_US×CLK_MHZ for clear/home, measured from the first setup cycle.
- Byte engine, 4-bit mode:
  - High nibble first in a fixed window of (SETUP + 2×PULSE) cycles.
  - Then the low nibble with the full CMD/LONG window.
  - Total = 27 + window cycles at default timings.
- Clear/home detection: rs=0 and byte ∈ {0x01, 0x02, 0x03}.
- rw=1 is passed through to the pin; no read-back is performed.
- lcd_enable outside READY is ignored; there is no queueing. If lcd_enable is held high, back-to-back transfers occur with exactly one READY cycle between them.
- Counters: width is ceil(log2(max(POWERUP_US, 4100, LONG_US)×CLK_MHZ + 1)). Counters reset to 0 at each phase start and never wrap.

Test Plan:
- CLK_MHZ=1, BUS4=0, release rst at cycle 0:
  - busy=1 for cycles 0..499.
  - First e rise at cycle 501 with lcd_data=0x30.
  - e high for exactly 13 cycles.
- Init with in_data=7'b1111110, BUS4=0:
  - Observe bytes 0x3C, 0x0F, 0x01, 0x06 on e pulses.
  - Gap from the 0x01 pulse start to the 0x06 pulse start is 2000 cycles.
  - busy falls only after the entry-mode window.
- READY, BUS4=0, lcd_enable pulse with lcd_bus=10'h241:
  - Next cycle busy=1, rs=1, rw=0, lcd_data=0x41.
  - busy=0 again after 50 cycles.
- BUS4=1, write lcd_bus=10'h0A5:
  - First pulse lcd_data=0xA0, second pulse lcd_data=0x50, rs=0.
  - Total busy period = 77 cycles.
- lcd_enable held high for 3 transfers:
  - Exactly 3 acceptances, each separated by one busy=0 cycle.
  - A toggle of lcd_bus mid-transfer does not change lcd_data.
- Assert rst in the middle of an e-high phase of a clear command:
  - Next cycle e=0, lcd_data=0, busy=1.
  - After release, the full power-up and init sequence repeats.
